// File: rtl/led_read_arbiter_if.sv
// Bundle of the requester, memory and status signals of led_read_arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface led_read_arbiter_if #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int CHANNELS          = 4
);
  logic [CHANNELS-1:0]                   req_valid;
  logic [CHANNELS*ADDRESS_BUS_WIDTH-1:0] req_address;
  logic [15:0]                           read_data;
  logic [CHANNELS-1:0]                   read_strobe;
  logic [ADDRESS_BUS_WIDTH-1:0]          mem_address;
  logic                                  mem_read_request;
  logic [15:0]                           mem_read_data;
  logic                                  mem_read_done;
  logic                                  busy;
  logic                                  timeout_error;
  logic                                  error_clear;

  modport master (
    output req_valid, req_address, mem_read_data, mem_read_done, error_clear,
    input  read_data, read_strobe, mem_address, mem_read_request, busy, timeout_error
  );

  modport slave (
    input  req_valid, req_address, mem_read_data, mem_read_done, error_clear,
    output read_data, read_strobe, mem_address, mem_read_request, busy, timeout_error
  );
endinterface

// File: rtl/led_read_arbiter.sv
// Round-robin arbiter sharing one 16-bit read memory among CHANNELS requesters,
// one transaction at a time, with a WAIT-state timeout and sticky error flag.
module led_read_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int CHANNELS          = 4,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input logic              clk,
  input logic              rst,
  led_read_arbiter_if.slave bus
);
  localparam int IDX_W   = $clog2(CHANNELS);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t                       state_reg, state_next;
  logic [IDX_W-1:0]             granted_reg, granted_next;
  logic [IDX_W-1:0]             last_grant_reg, last_grant_next;
  logic [ADDRESS_BUS_WIDTH-1:0] mem_address_reg, mem_address_next;
  logic [15:0]                  read_data_reg, read_data_next;
  logic [TIMER_W-1:0]           timer_reg, timer_next, timer_inc;
  logic                         timeout_error_reg;
  logic                         timeout_set;

  logic [IDX_W-1:0]    cand_idx [CHANNELS];
  logic [CHANNELS-1:0] cand_hit;
  logic [IDX_W-1:0]    rr_idx;
  logic                rr_found;
  logic [CHANNELS-1:0] strobe_vec;

  // Candidate gi is the channel gi+1 places after the last grant.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_rr
    assign cand_idx[gi] = IDX_W'((int'(last_grant_reg) + gi + 1) % CHANNELS);
    assign cand_hit[gi] = bus.req_valid[cand_idx[gi]];
  end

  // Scan from the farthest candidate down so the nearest requester wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_grant_reg;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx[i];
      end
    end
  end

  assign timer_inc = timer_reg + 1'b1;

  always_comb begin
    state_next       = state_reg;
    granted_next     = granted_reg;
    last_grant_next  = last_grant_reg;
    mem_address_next = mem_address_reg;
    read_data_next   = read_data_reg;
    timer_next       = timer_reg;
    timeout_set      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rr_found) begin
          granted_next     = rr_idx;
          mem_address_next = bus.req_address[rr_idx*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.mem_read_done) begin
          read_data_next = bus.mem_read_data;
          state_next     = DELIVER;
        end else if (timer_inc == TIMER_W'(TIMEOUT_CYCLES)) begin
          timer_next      = timer_inc;
          timeout_set     = 1'b1;
          last_grant_next = granted_reg;
          state_next      = IDLE;
        end else begin
          timer_next = timer_inc;
        end
      end
      DELIVER: begin
        last_grant_next = granted_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      granted_reg       <= '0;
      last_grant_reg    <= IDX_W'(CHANNELS - 1);
      mem_address_reg   <= '0;
      read_data_reg     <= '0;
      timer_reg         <= '0;
      timeout_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      granted_reg     <= granted_next;
      last_grant_reg  <= last_grant_next;
      mem_address_reg <= mem_address_next;
      read_data_reg   <= read_data_next;
      timer_reg       <= timer_next;
      // A same-cycle abort beats a clear request.
      if (timeout_set) begin
        timeout_error_reg <= 1'b1;
      end else if (bus.error_clear) begin
        timeout_error_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_strobe
    assign strobe_vec[gi] = (state_reg == DELIVER) && (granted_reg == IDX_W'(gi));
  end

  assign bus.read_strobe      = strobe_vec;
  assign bus.read_data        = read_data_reg;
  assign bus.mem_address      = mem_address_reg;
  assign bus.mem_read_request = (state_reg == ISSUE);
  assign bus.busy             = (state_reg != IDLE);
  assign bus.timeout_error    = timeout_error_reg;
endmodule
